lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit controller; consumer end of the decoder's MemWrite / ResultSrc=01 / AddressingControl (funct3 width) interface.
- Accepts one memory request from the execute stage and drives a word-wide data bus with byte enables.
- Returns sign- or zero-extended load data, or a store acknowledge, to writeback.
- Sits between execute/memory stage and data memory; stalls the pipeline via req_ready.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT, 16, cycles waiting for bus_gnt or bus_rvalid before error response; 0 disables.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store (MemWrite), 0 = load.
- req_width  in  3  AddressingControl: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address (ALUResult).
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  valid with rsp_valid: illegal width, misalignment fault or timeout.
- bus_req  out  1  bus request; held until bus_gnt.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  completion of oldest granted access (loads and stores); bus_rdata valid.
- bus_rdata  in  32  read word.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. Asynchronous reset forces IDLE and drops bus_req immediately. bus_rvalid arriving in IDLE is ignored.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid&req_ready, register all request fields.
  - Illegal width (011/110/111): go to RESP with err=1; no bus activity.
  - Otherwise go to REQ0.
- REQ0/REQ1: bus_req=1 with stable addr/we/be/wdata until bus_gnt; then go to WAIT0/WAIT1.
- WAIT0: on bus_rvalid, capture lane data; go to REQ1 if the access is split, else RESP.
- WAIT1: on bus_rvalid, merge lane data; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; then IDLE.
- Latency (aligned, gnt same cycle, rvalid next cycle): accept T, bus_req T+1, rvalid T+2, rsp_valid T+3. Illegal width: rsp_valid at T+1.
- Lanes, with o = addr[1:0]:
  - Byte: be = 0001<<o.
  - Half: be = 0011<<o.
  - Word: be = 1111.
  - wdata shifted left by 8*o.
  - Load data shifted right by 8*o, then sign-extended (B/H) or zero-extended (BU/HU/W).
- Misaligned: half with o=11, or word with o!=00.
  - Handling depends on the optional feature.
  - Byte accesses are never misaligned.
- Timeout: counter resets on every state entry. When it reaches TIMEOUT in REQx/WAITx: drop bus_req, go to RESP with err=1, rdata=0.
- back-to-back: req_ready low during RESP, so the next request is accepted no earlier than the cycle after rsp_valid.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: a misaligned access is split into two bus transactions.
  - First: addr&~3 with upper lanes.
  - Second: (addr&~3)+4 with remaining lanes; address wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC+4 = 0).
  - Load bytes are merged before extension.
  - The split is not atomic; err on either half aborts and reports err.
- Undefined: misaligned access produces no bus activity; rsp_valid with rsp_err=1 at T+1.

Decomposition:
- Package lsu_pkg holds:
  - Width encodings: LSU_B=3'b000, LSU_H=3'b001, LSU_W=3'b010, LSU_BU=3'b100, LSU_HU=3'b101.
  - State enum lsu_state_t.
  - Function computing be from width and offset.
- Sub-module lsu_extend (combinational): lane shift/merge and sign/zero extension. The FSM stays in lsu_ctrl.

Test Plan:
- LB addr 0x1003, bus_rdata 0x80AA_BBCC: be=1000, bus_addr 0x1000, rsp_rdata 0xFFFF_FF80. LBU gives 0x0000_0080.
- SH addr 0x2002, wdata 0x0000_1234: bus_we=1, be=1100, bus_wdata 0x1234_0000, rsp_valid after rvalid, rsp_err=0.
- LW addr 0x0101 with LSU_MISALIGN_SPLIT_EN, words 0x4433_2211 then 0x8877_6655: two grants (0x0100, be=1110; 0x0104, be=0001), rsp_rdata 0x5544_3322. Without the macro: no bus_req, rsp_err=1 at T+1.
- req_width 3'b011: no bus_req, rsp_valid with rsp_err=1 one cycle after accept.
- bus_gnt held low 16 cycles with TIMEOUT=16: bus_req drops, rsp_err=1, rsp_rdata=0, req_ready returns high.
- rst_n asserted during WAIT0: bus_req=0 and req_ready=1 immediately; a late bus_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: width encodings, FSM states and byte-enable helpers for lsu_ctrl
package lsu_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} lsu_state_t;
  // Enables across two consecutive words: [3:0] first word, [7:4] the following word
  function automatic logic [7:0] lsu_be(input logic [2:0] w, input logic [1:0] o);
    return {4'b0000, w[1] ? 4'hF : w[0] ? 4'h3 : 4'h1} << o;
  endfunction
  function automatic logic lsu_legal(input logic [2:0] w);
    return w inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
  endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: merges the two lane words, aligns to bit 0 and sign/zero extends
module lsu_extend import lsu_pkg::*; (
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [2:0]  width,
  input  logic [1:0]  off,
  output logic [31:0] rdata
);
  logic [31:0] w;
  assign w = 32'({hi, lo} >> {off, 3'b000});
  always_comb
    rdata = (width == LSU_W)  ? w :
            (width == LSU_H)  ? {{16{w[15]}}, w[15:0]} :
            (width == LSU_HU) ? {16'h0, w[15:0]} :
            (width == LSU_B)  ? {{24{w[7]}}, w[7:0]} :
                                {24'h0, w[7:0]};
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-request load/store controller driving a word bus with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two bus transactions.
module lsu_ctrl import lsu_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_width,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [31:0]           bus_rdata
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  lsu_state_t state, state_n;
  logic                  wr, err;
  logic [2:0]            width;
  logic [ADDR_WIDTH-1:0] addr, base;
  logic [31:0]           wdata, lo, hi, ext, cnt;
  logic [7:0]            be8, in_be8;
  logic [63:0]           wd64;
  logic                  accept, bad, split, busy, progress, tmo;
  assign be8      = lsu_be(width, addr[1:0]);
  assign in_be8   = lsu_be(req_width, req_addr[1:0]);
  assign wd64     = {32'h0, wdata} << {addr[1:0], 3'b000};
  assign base     = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign split    = SPLIT && |be8[7:4];
  assign accept   = req_valid && state == IDLE;
  assign bad      = !lsu_legal(req_width) || (!SPLIT && |in_be8[7:4]);
  assign busy     = state inside {REQ0, WAIT0, REQ1, WAIT1};
  assign progress = (state inside {REQ0, REQ1} && bus_gnt) || (state inside {WAIT0, WAIT1} && bus_rvalid);
  assign tmo      = busy && TIMEOUT != 0 && cnt == TMO_LAST && !progress;
  lsu_extend u_ext (.lo(lo), .hi(hi), .width(width), .off(addr[1:0]), .rdata(ext));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = accept ? (bad ? RESP : REQ0) : IDLE;
      REQ0:  state_n = bus_gnt ? WAIT0 : tmo ? RESP : REQ0;
      WAIT0: state_n = bus_rvalid ? (split ? REQ1 : RESP) : tmo ? RESP : WAIT0;
      REQ1:  state_n = bus_gnt ? WAIT1 : tmo ? RESP : REQ1;
      WAIT1: state_n = bus_rvalid || tmo ? RESP : WAIT1;
      default: state_n = IDLE;
    endcase
  end
  // The timeout counter restarts on every state entry and idles at zero outside bus states
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      wr    <= 1'b0;
      width <= LSU_B;
      addr  <= '0;
      wdata <= '0;
      err   <= 1'b0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      cnt <= (state_n != state || !busy) ? '0 : cnt + 32'd1;
      if (accept) begin
        wr    <= req_write;
        width <= req_width;
        addr  <= req_addr;
        wdata <= req_wdata;
        err   <= bad;
      end else if (tmo) err <= 1'b1;
      if (state == WAIT0 && bus_rvalid) lo <= bus_rdata;
      if (state == WAIT1 && bus_rvalid) hi <= bus_rdata;
    end
  always_comb begin
    req_ready = state == IDLE;
    bus_req   = state inside {REQ0, REQ1};
    bus_we    = bus_req && wr;
    bus_addr  = !bus_req ? '0 : state == REQ1 ? base + ADDR_WIDTH'(4) : base;
    bus_be    = !bus_req ? '0 : state == REQ1 ? be8[7:4] : be8[3:0];
    bus_wdata = !bus_req ? '0 : state == REQ1 ? wd64[63:32] : wd64[31:0];
    rsp_valid = state == RESP;
    rsp_err   = rsp_valid && err;
    rsp_rdata = rsp_valid && !err && !wr ? ext : '0;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench; a bus responder checks issued accesses and a monitor checks responses
module tb_lsu_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [2:0]  req_width = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we, bus_gnt = 0, bus_rvalid = 0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  logic [3:0]  bus_be;
  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] rdata;} bus_t;
  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  bus_t bq[$];
  rsp_t rq[$];
  int n_cmp = 0, n_err = 0;
  logic gnt_en = 1, hold_rv = 0, pend = 0;
  logic [31:0] pend_data = 0;
  int nreq, nrsp;

  lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
    bq.push_back('{we, a, be, wd, rd});
  endtask

  task automatic exp_rsp(input logic [31:0] rd, input logic e);
    rq.push_back('{rd, e});
  endtask

  task automatic do_req(input logic w, input logic [2:0] wd, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, output int n);
    int lat = 0;
    n = 0;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1; req_write = w; req_width = wd; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus_req) n++;
    end while (!rsp_valid && lat < 40);
    chk("latency", lat, exp_lat);
  endtask

  // Bus responder: grants a request seen at the falling edge, returns rvalid one cycle later
  initial forever begin
    bus_t e;
    @(negedge clk);
    bus_gnt = 0;
    bus_rvalid = 0;
    if (pend && !hold_rv) begin
      bus_rvalid = 1; bus_rdata = pend_data; pend = 0;
    end else if (bus_req && gnt_en && !pend) begin
      if (bq.size() == 0) begin
        chk("bus_unexpected", 1, 0);
        pend_data = 0;
      end else begin
        e = bq.pop_front();
        chk("bus_we", bus_we, e.we);
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_be", bus_be, e.be);
        if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
        pend_data = e.rdata;
      end
      bus_gnt = 1; pend = 1;
    end
  end

  initial forever begin
    rsp_t r;
    @(negedge clk);
    if (rsp_valid) begin
      if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        r = rq.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err", rsp_err, r.err);
      end
    end
  end

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_bus_be", bus_be, 0);
    @(negedge clk) rst_n = 1;
    exp_bus(0, 32'h1000, 4'b1000, 0, 32'h80AA_BBCC); exp_rsp(32'hFFFF_FF80, 0);
    do_req(0, 3'b000, 32'h1003, 0, 3, nreq);
    exp_bus(0, 32'h1000, 4'b1000, 0, 32'h80AA_BBCC); exp_rsp(32'h0000_0080, 0);
    do_req(0, 3'b100, 32'h1003, 0, 3, nreq);
    exp_bus(1, 32'h2000, 4'b1100, 32'h1234_0000, 32'hDEAD_BEEF); exp_rsp(0, 0);
    do_req(1, 3'b001, 32'h2002, 32'h0000_1234, 3, nreq);
    exp_bus(0, 32'h3000, 4'b1100, 0, 32'h8001_1234); exp_rsp(32'hFFFF_8001, 0);
    do_req(0, 3'b001, 32'h3002, 0, 3, nreq);
    exp_bus(0, 32'h3000, 4'b0011, 0, 32'h0000_F00D); exp_rsp(32'h0000_F00D, 0);
    do_req(0, 3'b101, 32'h3000, 0, 3, nreq);
    exp_bus(0, 32'h4000, 4'b1111, 0, 32'h1234_5678); exp_rsp(32'h1234_5678, 0);
    do_req(0, 3'b010, 32'h4000, 0, 3, nreq);
    exp_bus(1, 32'h5000, 4'b0010, 32'h0000_AB00, 0); exp_rsp(0, 0);
    do_req(1, 3'b000, 32'h5001, 32'h0000_00AB, 3, nreq);
`ifdef LSU_MISALIGN_SPLIT_EN
    exp_bus(0, 32'h0100, 4'b1110, 0, 32'h4433_2211);
    exp_bus(0, 32'h0104, 4'b0001, 0, 32'h8877_6655); exp_rsp(32'h5544_3322, 0);
    do_req(0, 3'b010, 32'h0101, 0, 5, nreq);
    chk("split_nreq", nreq, 2);
    exp_bus(1, 32'h0000, 4'b1000, 32'hEF00_0000, 0);
    exp_bus(1, 32'h0004, 4'b0001, 32'h0000_00BE, 0); exp_rsp(0, 0);
    do_req(1, 3'b001, 32'h0003, 32'h0000_BEEF, 5, nreq);
    exp_bus(0, 32'hFFFF_FFFC, 4'b1000, 0, 32'h7F00_0000);
    exp_bus(0, 32'h0000_0000, 4'b0001, 0, 32'h0000_0080); exp_rsp(32'hFFFF_807F, 0);
    do_req(0, 3'b001, 32'hFFFF_FFFF, 0, 5, nreq);
`else
    exp_rsp(0, 1);
    do_req(0, 3'b010, 32'h0101, 0, 1, nreq);
    chk("misalign_nreq", nreq, 0);
    exp_rsp(0, 1);
    do_req(1, 3'b001, 32'h0003, 32'h0000_BEEF, 1, nreq);
    exp_rsp(0, 1);
    do_req(0, 3'b001, 32'hFFFF_FFFF, 0, 1, nreq);
`endif
    exp_rsp(0, 1);
    do_req(0, 3'b011, 32'h0200, 0, 1, nreq);
    chk("illegal_nreq", nreq, 0);
    exp_rsp(0, 1);
    do_req(1, 3'b111, 32'h0204, 32'hFFFF_FFFF, 1, nreq);
    gnt_en = 0;
    exp_rsp(0, 1);
    do_req(0, 3'b010, 32'h7000, 0, 17, nreq);
    chk("timeout_nreq", nreq, 16);
    gnt_en = 1;
    @(negedge clk);
    chk("timeout_ready", req_ready, 1);
    // Reset while the access is waiting for rvalid; the late rvalid must be ignored
    hold_rv = 1;
    exp_bus(0, 32'h6000, 4'b1111, 0, 32'h1111_1111);
    req_valid = 1; req_write = 0; req_width = 3'b010; req_addr = 32'h6000;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_req_ready", req_ready, 1);
    @(posedge clk);
    #1 rst_n = 1;
    hold_rv = 0;
    nrsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("arst_no_rsp", nrsp, 0);
    chk("bus_queue_empty", bq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
